mem_stage: RTL

//   Pipeline MEM stage: consumes the EXE/MEM register outputs, resolves the branch, and accesses the 8-bit data memory.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_stage_data_memory.sv | 46 ++++
 rtl/mem_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// MEM stage shared types: data width, default DMEM depth,
// WB select encoding and the MEM/WB passthrough bundle.
package mem_stage_pkg;

  localparam int DMEM_DEPTH_DEF = 64;
  localparam int DATA_W = 8;

  typedef enum logic {
    MEM_TO_REG_ALU = 1'b0,
    MEM_TO_REG_MEM = 1'b1
  } wb_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    wb_sel_e           mem_to_reg;
    logic              reg_write;
  } mem_wb_t;

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-wide data memory: synchronous write, registered
// read (read-before-write), synchronous clear of all words.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // non-power-of-two depths leave holes in the address space
  assign in_range = (32'(addr) < 32'(DEPTH));

  // storage: clear on reset, else write the addressed word
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && in_range) begin
      mem[addr] <= wdata;
    end
  end

  // read port: old contents on a same-edge write
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re && in_range) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: branch resolve, data memory, MEM/WB registers.
// MEM_STAGE_BOUNDS_CHECK_EN adds range check and mem_fault.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_SIZE    = 10,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PC_SIZE-1:0] PC_jump_in,
  input  logic               zero_in,
  input  logic [DATA_W-1:0]  ALU_result_in,
  input  logic [DATA_W-1:0]  write_data_in,
  input  logic               branch_in,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic               mem_to_reg_in,
  input  logic               reg_write_in,
  output logic               pc_src,
  output logic [PC_SIZE-1:0] PC_branch,
  output logic [DATA_W-1:0]  read_data,
  output logic [DATA_W-1:0]  ALU_result_out,
  output logic               mem_to_reg_out,
`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  output logic               mem_fault,
`endif
  output logic               reg_write_out
);

  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [DMEM_AW-1:0] addr;
  logic               we;
  logic               re;
  mem_wb_t            wb_q;

  assign pc_src    = branch_in & zero_in & ~reset;
  assign PC_branch = PC_jump_in;
  assign addr      = ALU_result_in[DMEM_AW-1:0];

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  logic viol;

  assign viol = (mem_read_in | mem_write_in)
              & (32'(ALU_result_in) >= 32'(DMEM_DEPTH));
  assign we   = mem_write_in & ~viol;
  assign re   = mem_read_in & ~viol;

  // fault flag tracks the access of the previous edge
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= viol;
    end
  end
`else
  assign we = mem_write_in;
  assign re = mem_read_in;
`endif

  data_memory #(
    .DEPTH (DMEM_DEPTH),
    .AW    (DMEM_AW)
  ) u_dmem (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (write_data_in),
    .rdata (read_data)
  );

  // MEM/WB passthrough registers, no stall or flush
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q.alu_result <= ALU_result_in;
      wb_q.mem_to_reg <= wb_sel_e'(mem_to_reg_in);
      wb_q.reg_write  <= reg_write_in;
    end
  end

  assign ALU_result_out = wb_q.alu_result;
  assign mem_to_reg_out = wb_q.mem_to_reg;
  assign reg_write_out  = wb_q.reg_write;

endmodule
